// File: rtl/count_display_driver.sv
// Seconds-counter display driver: double-dabble BCD conversion of the counter value
// feeding a two-digit multiplexed active-low seven-segment display with end-of-phase blink.
module count_display_driver #(
    parameter int unsigned pSCAN_DIV     = 1000,
    parameter int unsigned pBLINK_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] count,
    input  logic       pre_last,
    input  logic       last,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       busy
);
    localparam int unsigned SW = $clog2(pSCAN_DIV);
    localparam int unsigned FW = (pBLINK_FRAMES > 1) ? $clog2(pBLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(pSCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(pBLINK_FRAMES - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [6:0]    val_q, val_d;
    logic [14:0]   scr_q, scr_d;
    logic [2:0]    it_q, it_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [14:0]   adj, shifted;

    logic [SW-1:0] scan_q, scan_d;
    logic          dig_q, dig_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          blink_on;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            4'hF:    return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Scratch register layout is {tens, ones, binary}; one add-3/shift step per clock.
    always_comb begin
        adj = scr_q;
        if (scr_q[14:11] >= 4'd5) adj[14:11] = scr_q[14:11] + 4'd3;
        if (scr_q[10:7]  >= 4'd5) adj[10:7]  = scr_q[10:7]  + 4'd3;
        shifted = adj << 1;

        state_d = state_q;
        val_d   = val_q;
        scr_d   = scr_q;
        it_d    = it_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (count != val_q) begin
                    state_d = SHIFT;
                    val_d   = count;
                    scr_d   = {8'h00, count};
                    it_d    = '0;
                end
            end
            SHIFT: begin
                scr_d = shifted;
                it_d  = it_q + 3'd1;
                if (it_q == 3'd6) begin
                    state_d = IDLE;
                    if (val_q > 7'd99) begin
                        tens_d = 4'hF;
                        ones_d = 4'hF;
                    end else begin
                        tens_d = shifted[14:11];
                        ones_d = shifted[10:7];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blink_on = pre_last | last;
        scan_d   = scan_q;
        dig_d    = dig_q;
        frame_d  = frame_q;
        blink_d  = blink_q;
        if (en) begin
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                dig_d  = ~dig_q;
                if (dig_q) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = '0;
                        blink_d = ~blink_q;
                    end else begin
                        frame_d = frame_q + FW'(1);
                    end
                end
            end else begin
                scan_d = scan_q + SW'(1);
            end
        end
        // Outside the ending phase the blink timer restarts so the first blank is a full half-period away.
        if (!blink_on) begin
            frame_d = '0;
            blink_d = 1'b0;
        end

        an_d  = 2'b11;
        seg_d = 7'h7F;
        if (en) begin
            an_d = dig_q ? 2'b01 : 2'b10;
            if (!(blink_on && blink_q)) begin
                if (dig_q) seg_d = (tens_q == 4'd0) ? 7'h7F : seg_decode(tens_q);
                else       seg_d = seg_decode(ones_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            scr_q   <= '0;
            it_q    <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            scan_q  <= '0;
            dig_q   <= 1'b0;
            frame_q <= '0;
            blink_q <= 1'b0;
            seg_q   <= '1;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            scr_q   <= scr_d;
            it_q    <= it_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            scan_q  <= scan_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_n    = seg_q;
    assign an_n     = an_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with a 4-clock digit dwell and 2-frame blink.
module tb_count_display_driver;
    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] count;
    logic       pre_last;
    logic       last;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

    typedef struct {
        logic [6:0] cnt;
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] so;
        logic [6:0] st;
    } vec_t;
    vec_t tbl[8];

    count_display_driver #(.pSCAN_DIV(4), .pBLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .count(count), .pre_last(pre_last), .last(last),
        .seg_n(seg_n), .an_n(an_n), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (an_n == 2'b00) overlap++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic convert(input logic [6:0] v, output int bc, output bit to);
        int g;
        count = v;
        bc = 0;
        to = 1'b0;
        g = 0;
        while (!busy && g < 5) begin tick(); g++; end
        if (!busy) begin
            to = 1'b1;
            return;
        end
        while (busy && g < 30) begin bc++; tick(); g++; end
        if (busy) to = 1'b1;
    endtask

    task automatic sync_ones(output bit ok);
        logic [1:0] prev;
        int g;
        g = 0;
        prev = an_n;
        tick();
        while (!(an_n == 2'b10 && prev != 2'b10) && g < 20) begin prev = an_n; tick(); g++; end
        ok = (an_n == 2'b10 && prev != 2'b10);
    endtask

    task automatic scan_check(input string nm, input logic [6:0] so, input logic [6:0] st);
        bit ok;
        int n;
        logic [6:0] seen;
        tick();
        sync_ones(ok);
        check({nm, "_sync"}, int'(ok), 1);
        n = 0;
        seen = so;
        while (an_n == 2'b10 && n < 10) begin
            if (seg_n != so) seen = seg_n;
            n++;
            tick();
        end
        check({nm, "_ones_dwell"}, n, 4);
        check({nm, "_ones_seg"}, int'(seen), int'(so));
        n = 0;
        seen = st;
        while (an_n == 2'b01 && n < 10) begin
            if (seg_n != st) seen = seg_n;
            n++;
            tick();
        end
        check({nm, "_tens_dwell"}, n, 4);
        check({nm, "_tens_seg"}, int'(seen), int'(st));
    endtask

    initial begin
        int bc;
        bit to;
        bit ok;
        int n, g, nchg;
        int chg[4];
        int ph, ph_prev, bad_tens, idle_an;
        logic [1:0] prev;

        tbl[0] = '{7'd7,   4'd0, 4'd7, 7'h78, 7'h7F};
        tbl[1] = '{7'd42,  4'd4, 4'd2, 7'h24, 7'h19};
        tbl[2] = '{7'd10,  4'd1, 4'd0, 7'h40, 7'h79};
        tbl[3] = '{7'd58,  4'd5, 4'd8, 7'h00, 7'h12};
        tbl[4] = '{7'd63,  4'd6, 4'd3, 7'h30, 7'h02};
        tbl[5] = '{7'd120, 4'hF, 4'hF, 7'h3F, 7'h3F};
        tbl[6] = '{7'd100, 4'hF, 4'hF, 7'h3F, 7'h3F};
        tbl[7] = '{7'd99,  4'd9, 4'd9, 7'h10, 7'h10};

        // Reset and enable
        rst = 1'b1; en = 1'b0; count = 7'd99; pre_last = 1'b0; last = 1'b0;
        repeat (3) tick();
        check("rst_seg", int'(seg_n), 'h7F);
        check("rst_an", int'(an_n), 'h3);
        check("rst_busy", int'(busy), 0);
        check("rst_tens", int'(bcd_tens), 0);
        check("rst_ones", int'(bcd_ones), 0);
        rst = 1'b0;
        en = 1'b1;
        convert(7'd99, bc, to);
        check("first_timeout", int'(to), 0);
        check("first_busy_len", bc, 7);
        check("first_tens", int'(bcd_tens), 9);
        check("first_ones", int'(bcd_ones), 9);
        scan_check("first_scan", 7'h10, 7'h10);

        // Directed vectors with display decode
        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].cnt, bc, to);
            check($sformatf("vec%0d_timeout", i), int'(to), 0);
            check($sformatf("vec%0d_busy_len", i), bc, 7);
            check($sformatf("vec%0d_bcd", i), int'({bcd_tens, bcd_ones}), int'({tbl[i].t, tbl[i].o}));
            scan_check($sformatf("vec%0d_scan", i), tbl[i].so, tbl[i].st);
        end

        // Sweep 0..99
        for (int v = 0; v < 100; v++) begin
            convert(7'(v), bc, to);
            check($sformatf("sweep%0d_busy", v), bc, 7);
            check($sformatf("sweep%0d_bcd", v), int'({bcd_tens, bcd_ones}), ((v / 10) << 4) | (v % 10));
        end

        // Re-trigger during a conversion
        count = 7'd42;
        g = 0;
        while (!busy && g < 5) begin tick(); g++; end
        check("retrig_start", int'(busy), 1);
        repeat (2) tick();
        count = 7'd41;
        g = 0;
        while (busy && g < 20) begin tick(); g++; end
        check("retrig_first_bcd", int'({bcd_tens, bcd_ones}), 'h42);
        tick();
        check("retrig_restart_busy", int'(busy), 1);
        g = 0;
        while (busy && g < 20) begin tick(); g++; end
        check("retrig_second_bcd", int'({bcd_tens, bcd_ones}), 'h41);

        // Blink while pre_last is set
        convert(7'd1, bc, to);
        check("blink_conv", int'({bcd_tens, bcd_ones}), 'h01);
        pre_last = 1'b1;
        nchg = 0; ph_prev = -1; bad_tens = 0; idle_an = 0;
        for (int t = 0; t < 80; t++) begin
            tick();
            if (an_n == 2'b11) idle_an++;
            if (an_n == 2'b01 && seg_n != 7'h7F) bad_tens++;
            if (an_n == 2'b10) begin
                ph = (seg_n == 7'h7F) ? 1 : 0;
                if (ph_prev != -1 && ph != ph_prev && nchg < 4) begin
                    chg[nchg] = t;
                    nchg++;
                end
                ph_prev = ph;
            end
        end
        check("blink_changes", int'(nchg >= 3), 1);
        if (nchg >= 3) begin
            check("blink_half1", chg[1] - chg[0], 16);
            check("blink_half2", chg[2] - chg[1], 16);
        end
        check("blink_tens_blank", bad_tens, 0);
        check("blink_an_cycles", idle_an, 0);
        g = 0;
        prev = an_n;
        tick();
        while (!(an_n == 2'b10 && prev != 2'b10 && seg_n == 7'h7F) && g < 40) begin
            prev = an_n; tick(); g++;
        end
        check("blink_found_blank", int'(seg_n), 'h7F);
        pre_last = 1'b0;
        tick();
        check("unblank_seg", int'(seg_n), 'h79);
        check("unblank_an", int'(an_n), 'h2);

        // Enable toggle resumes on the held digit
        sync_ones(ok);
        check("en_sync", int'(ok), 1);
        en = 1'b0;
        tick();
        check("en_off_an", int'(an_n), 'h3);
        check("en_off_seg", int'(seg_n), 'h7F);
        repeat (5) tick();
        check("en_off_hold_an", int'(an_n), 'h3);
        en = 1'b1;
        tick();
        check("en_resume_seg", int'(seg_n), 'h79);
        n = 0;
        while (an_n == 2'b10 && n < 10) begin n++; tick(); end
        check("en_resume_remaining", n, 3);
        check("en_resume_next", int'(an_n), 'h1);

        // Reset in the middle of a conversion
        count = 7'd55;
        n = 0;
        g = 0;
        while (n < 4 && g < 10) begin
            tick();
            if (busy) n++;
            g++;
        end
        check("midrst_busy_seen", n, 4);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_seg", int'(seg_n), 'h7F);
        check("midrst_an", int'(an_n), 'h3);
        check("midrst_busy", int'(busy), 0);
        check("midrst_bcd", int'({bcd_tens, bcd_ones}), 0);
        repeat (6) tick();
        check("midrst_hold_bcd", int'({bcd_tens, bcd_ones}), 0);
        count = 7'd0;
        rst = 1'b0;
        repeat (12) tick();
        check("midrst_after_bcd", int'({bcd_tens, bcd_ones}), 0);
        check("midrst_after_busy", int'(busy), 0);

        check("anode_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/count_display_driver.md
# count_display_driver

Display-side consumer of the traffic-light seconds counter. Takes the counter's 7-bit remaining-time value and its `pre_last`/`last` flags, converts the value to two BCD digits with an iterative shift-add-3 engine, and drives a two-digit, time-multiplexed, active-low seven-segment display. While the phase is ending, the display blinks. It sits between the second counter and the board-level LED/segment pins, one instance per signal head.

## Interface
- `pSCAN_DIV`, 1000: clocks each digit stays lit; must be ≥ 2.
- `pBLINK_FRAMES`, 50: full scan frames (ones digit + tens digit) per blink half-period; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: display enable. Conversion runs regardless of `en`.
- `count` in 7: remaining seconds from the counter. Legal range is 0–127.
- `pre_last` in 1: counter is one step before terminal.
- `last` in 1: counter is at terminal.
- `seg_n` out 7: {g,f,e,d,c,b,a}, active-low, registered.
- `an_n` out 2: digit anodes, active-low. Bit 0 is ones, bit 1 is tens. Registered.
- `bcd_tens` out 4: converted tens digit, registered.
- `bcd_ones` out 4: converted ones digit, registered.
- `busy` out 1: a conversion is in progress.

## Operation
- **Reset values:** `seg_n`=7'h7F, `an_n`=2'b11, `bcd_tens`=`bcd_ones`=0, `busy`=0. Internal state resets as follows: sampled value = 0, digit select = ones, scan count = 0, frame count = 0, blink phase = 0, FSM = IDLE.
- **Conversion FSM.** There are two states, IDLE and SHIFT.
  - IDLE → SHIFT when `count` ≠ the last sampled value. On that transition the block latches `count` and clears the scratch register.
  - SHIFT runs exactly 7 iterations. Each iteration first adds 3 to any BCD nibble ≥ 5, then shifts the {tens, ones, value} register left by 1.
  - After the 7th iteration the FSM writes `bcd_tens`/`bcd_ones` and returns to IDLE.
- **Changes during SHIFT.** A `count` change during SHIFT is not lost. Back in IDLE the FSM compares again and starts a new conversion on the next cycle.
- **Out-of-range values.** If the sampled value is > 99, `bcd_tens` = `bcd_ones` = 4'hF. This is the dash code.
- **Scan.** The scan counter runs 0..`pSCAN_DIV`−1. At wrap it toggles the digit select. Every tens→ones toggle ends a frame.
- **Blink.** The frame counter runs 0..`pBLINK_FRAMES`−1. At wrap it toggles the blink phase.
- **Segment decode (active-low).**
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - 4'hF is a dash, 3F. Blank is 7F.
- **Tens blanking.** When `bcd_tens`=0, the tens digit shows blank; `an_n` still cycles.
- **Blink blanking.** When `pre_last`|`last` is 1 and blink phase = 1, both digits show blank (`seg_n`=7F) and `an_n` keeps cycling. When `pre_last`=`last`=0, blink phase is forced to 0 and the frame counter is cleared.
- **`en`=0.**
  - `an_n`=11 and `seg_n`=7F on the next edge.
  - The scan, frame and blink counters hold their values.
  - When `en` returns to 1, the block resumes on the held digit.
- **Reset mid-conversion.** Conversion aborts, outputs take reset values, and no partial BCD is ever written.

## Timing
- **Conversion latency.** Let `count` differ from the sampled value at edge T, seen in IDLE.
  - `busy`=1 from T+1 through T+7.
  - `bcd_*` are valid at T+8, and `busy`=0 at T+8.
  - Back-to-back change worst case: 9 cycles from the change to the new start.
- **Display update.** `seg_n`/`an_n` register from the current `bcd_*`, digit select and blink state. Their latency is 1 cycle after any of these changes.
- **Digit dwell.** Each digit stays on for exactly `pSCAN_DIV` clocks. The frame period is 2·`pSCAN_DIV`. The blink half-period is 2·`pSCAN_DIV`·`pBLINK_FRAMES` clocks.
- **Anode overlap.** `an_n` never has both bits 0.
- **Simultaneous events.** When a scan wrap and a frame wrap fall on the same edge, both apply on that same edge. A `count` change on the same edge as `bcd_*` being written is handled normally: IDLE is entered, and the next cycle starts the new conversion.

## Test plan
Bench parameters: `pSCAN_DIV`=4, `pBLINK_FRAMES`=2.
- **Reset and enable.** Hold `rst`=1 with `count`=99 → `seg_n`=7F, `an_n`=11, `busy`=0. Release `rst` and set `en`=1 → `busy` high for 7 cycles, then `bcd_tens`=9 and `bcd_ones`=9. The ones digit shows 10 with `an_n`=10 for 4 clocks, then the tens digit shows 10 with `an_n`=01.
- **Conversion sweep.** Set `count`=7 → `bcd`=0/7 at T+8. The tens digit is blanked (7F while `an_n`=01) and the ones digit shows 78. Sweep 0..99 → every BCD pair is correct.
- **Re-trigger.** Change `count` from 42 to 41 during `busy` → the first result 4/2 appears, then a second conversion produces 4/1 with no result dropped.
- **Out of range.** Apply `count`=120 → `bcd`=F/F and both digits show 3F.
- **Blink.** Hold `count`=1 with `pre_last`=1 → the display alternates between shown and fully blank every 16 clocks, with `an_n` cycling throughout. Drop `pre_last` → the display is immediately unblanked.
- **`en` toggle and mid-conversion reset.**
  - Drop `en` → `an_n`=11 on the next cycle. Raise it → the display resumes on the held digit.
  - Assert `rst` at T+4 of a conversion → all outputs return to reset values at once, and `bcd` stays 0.
